// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush, NOP bubbles and a saturating backpressure counter.
module pipe_stage_reg #(
   parameter int                 DATA_W    = 80,
   parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
   parameter bit                 SKID_EN   = 1'b1,
   parameter int                 CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [1:0]        occ_q,        occ_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic              accept, drain;

   // With the skid buffer in_ready is a pure flop output; without it, it must
   // look at out_ready to sustain one bundle per cycle from a single register.
   assign in_ready  = SKID_EN ? !skid_valid_q : (!main_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign drain     = main_valid_q && out_ready;

   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign occupancy = occ_q;
   assign stall_cnt = cnt_q;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_data_d  = NOP_VALUE;
         skid_valid_d = 1'b0;
         skid_data_d  = NOP_VALUE;
      end else if (skid_valid_q) begin
         // Full: in_ready is low, so the only move is skid -> main on drain.
         if (drain) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_data_d  = NOP_VALUE;
         end
      end else if (accept && (!main_valid_q || drain)) begin
         main_valid_d = 1'b1;
         main_data_d  = in_data;
      end else if (accept && SKID_EN) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end else if (drain) begin
         main_valid_d = 1'b0;
         main_data_d  = NOP_VALUE;
      end
      occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)
         cnt_d = '0;
      else if (main_valid_q && !out_ready && cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= NOP_VALUE;
         skid_valid_q <= 1'b0;
         skid_data_q  <= NOP_VALUE;
         occ_q        <= 2'd0;
         cnt_q        <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         occ_q        <= occ_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid and non-skid instances share one stimulus and are
// compared every cycle against a FIFO-queue model, plus directed literal checks.
module tb_pipe_stage_reg;

   localparam int          DW  = 16;
   localparam int          CW  = 4;
   localparam logic [15:0] NOP = 16'hDEAD;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush, in_valid, out_ready, cnt_clr;
   logic [DW-1:0] in_data;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   // g=0: skid buffer, g=1: single register
   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic          ov, ir;
      logic [DW-1:0] od;
      logic [1:0]    occ;
      logic [CW-1:0] sc;
      logic [DW-1:0] q[$];
      int            m_cnt;

      pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID_EN(g == 0), .CNT_W(CW)) u_dut (
         .clk(clk), .rst(rst), .flush(flush),
         .in_valid(in_valid), .in_ready(ir), .in_data(in_data),
         .out_valid(ov), .out_ready(out_ready), .out_data(od),
         .occupancy(occ), .cnt_clr(cnt_clr), .stall_cnt(sc)
      );

      always @(posedge clk or posedge rst) begin
         bit rdy, acc, drn;
         if (rst) begin
            q.delete();
            m_cnt = 0;
         end else begin
            rdy = (g == 0) ? (q.size() < 2) : (q.size() == 0 || out_ready);
            acc = in_valid && rdy;
            drn = q.size() > 0 && out_ready;
            if (cnt_clr) m_cnt = 0;
            else if (q.size() > 0 && !out_ready && m_cnt < 15) m_cnt++;
            if (flush) q.delete();
            else begin
               if (drn) void'(q.pop_front());
               if (acc) q.push_back(in_data);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic chk_model(input int g, input logic ov, input logic [DW-1:0] od,
                            input logic ir, input logic [1:0] occ, input logic [CW-1:0] sc,
                            input int sz, input logic [DW-1:0] head, input int cnt);
      logic exp_ir;
      exp_ir = (g == 0) ? (sz < 2) : (sz == 0 || out_ready);
      chk($sformatf("d%0d_out_valid", g), ov, sz > 0);
      chk($sformatf("d%0d_out_data", g), od, sz > 0 ? head : NOP);
      chk($sformatf("d%0d_in_ready", g), ir, exp_ir);
      chk($sformatf("d%0d_occupancy", g), occ, sz);
      chk($sformatf("d%0d_stall_cnt", g), sc, cnt);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk_model(0, g_dut[0].ov, g_dut[0].od, g_dut[0].ir, g_dut[0].occ, g_dut[0].sc,
                   g_dut[0].q.size(), g_dut[0].q.size() > 0 ? g_dut[0].q[0] : NOP, g_dut[0].m_cnt);
         chk_model(1, g_dut[1].ov, g_dut[1].od, g_dut[1].ir, g_dut[1].occ, g_dut[1].sc,
                   g_dut[1].q.size(), g_dut[1].q.size() > 0 ? g_dut[1].q[0] : NOP, g_dut[1].m_cnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ov0"},  g_dut[0].ov,  1'b0);
      chk({tag, "_od0"},  g_dut[0].od,  NOP);
      chk({tag, "_occ0"}, g_dut[0].occ, 2'd0);
      chk({tag, "_sc0"},  g_dut[0].sc,  4'd0);
      chk({tag, "_ir0"},  g_dut[0].ir,  1'b1);
      chk({tag, "_ov1"},  g_dut[1].ov,  1'b0);
      chk({tag, "_od1"},  g_dut[1].od,  NOP);
      chk({tag, "_occ1"}, g_dut[1].occ, 2'd0);
      chk({tag, "_sc1"},  g_dut[1].sc,  4'd0);
      chk({tag, "_ir1"},  g_dut[1].ir,  1'b1);
   endtask

   initial begin
      int pct;
      flush = 0; in_valid = 0; in_data = '0; out_ready = 0; cnt_clr = 0;
      #2 rst = 1;
      #1 chk_reset("rst");
      @(negedge clk); rst = 0;
      step();

      // stream A..D, one per cycle, both variants
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_data = 16'h0A00 + 16'(i);
         step();
         chk("t1_ov0", g_dut[0].ov, 1'b1);
         chk("t1_od0", g_dut[0].od, 16'h0A00 + 16'(i));
         chk("t1_od1", g_dut[1].od, 16'h0A00 + 16'(i));
      end
      in_valid = 0;
      step();
      chk("t1_bubble0", g_dut[0].od, NOP);
      chk("t1_bubble1", g_dut[1].od, NOP);

      // backpressure fills the skid buffer
      out_ready = 0; in_valid = 1;
      in_data = 16'h0B00; step();
      in_data = 16'h0B01; step();
      in_data = 16'h0B02; step();
      chk("t2_occ",   g_dut[0].occ, 2'd2);
      chk("t2_ir",    g_dut[0].ir,  1'b0);
      chk("t2_head",  g_dut[0].od,  16'h0B00);
      chk("t2_sc",    g_dut[0].sc,  4'd2);
      chk("t2_occ1",  g_dut[1].occ, 2'd1);
      out_ready = 1;
      step(); chk("t2_out1", g_dut[0].od, 16'h0B01);
      step(); chk("t2_out2", g_dut[0].od, 16'h0B02);
      in_valid = 0;
      step(); chk("t2_empty", g_dut[0].ov, 1'b0);
      chk("t2_sc_after", g_dut[0].sc, 4'd2);

      // flush while full with a concurrent input
      out_ready = 0; in_valid = 1;
      in_data = 16'h0C00; step();
      in_data = 16'h0C01; step();
      in_data = 16'h0C02; flush = 1; step(); flush = 0;
      chk("t3_ov",  g_dut[0].ov,  1'b0);
      chk("t3_od",  g_dut[0].od,  NOP);
      chk("t3_occ", g_dut[0].occ, 2'd0);
      chk("t3_ir",  g_dut[0].ir,  1'b1);
      in_data = 16'h0C03; out_ready = 1; step();
      chk("t3_next", g_dut[0].od, 16'h0C03);
      in_valid = 0; step();

      // counter saturation and clear priority
      cnt_clr = 1; step(); cnt_clr = 0;
      chk("t4_clr0", g_dut[0].sc, 4'd0);
      out_ready = 0; in_valid = 1; in_data = 16'h0D00; step();
      in_valid = 0;
      repeat (20) step();
      chk("t4_sat0", g_dut[0].sc, 4'd15);
      chk("t4_sat1", g_dut[1].sc, 4'd15);
      cnt_clr = 1; step();
      chk("t4_clr_win", g_dut[0].sc, 4'd0);
      cnt_clr = 0; step();
      chk("t4_restart", g_dut[0].sc, 4'd1);
      out_ready = 1; step();

      // asynchronous reset between edges in the middle of a stream
      in_valid = 1; in_data = 16'h0E00; step();
      in_data = 16'h0E01; step();
      #3 rst = 1;
      #1 chk_reset("midrst");
      step();
      @(negedge clk); in_valid = 0; rst = 0;
      step();
      chk("t5_nopulse0", g_dut[0].ov, 1'b0);
      chk("t5_nopulse1", g_dut[1].ov, 1'b0);
      step();
      chk("t5_quiet0", g_dut[0].occ, 2'd0);

      // randomized traffic with varying downstream pressure
      pct = 80;
      for (int i = 0; i < 10000; i++) begin
         if (i % 500 == 0) pct = $urandom_range(10, 100);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = DW'($urandom);
         out_ready = ($urandom_range(0, 99) < pct);
         flush     = ($urandom_range(0, 63) == 0);
         cnt_clr   = ($urandom_range(0, 31) == 0);
         step();
      end
      in_valid = 0; flush = 0; cnt_clr = 0; out_ready = 1;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
